// File: rtl/memory_arbiter_if.sv
// rtl/memory_arbiter_if.sv - cache-side and memory-side signal bundle for memory_arbiter
interface memory_arbiter_if;
    logic        IRequest;
    logic [31:0] IAddress;
    logic [31:0] IReadData;
    logic        IDone;
    logic        IError;

    logic        DRequest;
    logic        DWrite;
    logic [1:0]  DWidth;
    logic [31:0] DAddress;
    logic [31:0] DWriteData;
    logic [31:0] DReadData;
    logic        DDone;
    logic        DError;

    logic [1:0]  MemoryDataWidth;
    logic [31:0] MemoryAddress;
    logic [31:0] MemoryDataIn;
    logic [31:0] MemoryDataOut;
    logic        MemoryBusCycle;
    logic        MemoryBusStrobe;
    logic        MemoryBusReadWrite;
    logic        MemoryBusAcknowledge;
    logic        MemoryBusStall;

    modport master (
        input  IRequest, IAddress, DRequest, DWrite, DWidth, DAddress, DWriteData,
               MemoryDataOut, MemoryBusAcknowledge, MemoryBusStall,
        output IReadData, IDone, IError, DReadData, DDone, DError,
               MemoryDataWidth, MemoryAddress, MemoryDataIn,
               MemoryBusCycle, MemoryBusStrobe, MemoryBusReadWrite
    );

    modport slave (
        output IRequest, IAddress, DRequest, DWrite, DWidth, DAddress, DWriteData,
               MemoryDataOut, MemoryBusAcknowledge, MemoryBusStall,
        input  IReadData, IDone, IError, DReadData, DDone, DError,
               MemoryDataWidth, MemoryAddress, MemoryDataIn,
               MemoryBusCycle, MemoryBusStrobe, MemoryBusReadWrite
    );
endinterface

// File: rtl/memory_arbiter.sv
// rtl/memory_arbiter.sv - two-master (instruction/data) arbiter onto one memory bus with timeout
module memory_arbiter #(
    parameter int unsigned TimeoutCycles = 255
) (
    input logic             Clock,
    input logic             Reset,
    memory_arbiter_if.master bus
);
    typedef enum logic [1:0] {IDLE, STROBE, WAIT, RESPOND} state_t;

    localparam logic [15:0] Limit = 16'(TimeoutCycles - 1);

    state_t      state, state_next;
    logic [15:0] count, count_next;
    logic        grant_d, grant_d_next;
    logic        last_d, last_d_next;
    logic        cyc, cyc_next, stb, stb_next, rw, rw_next;
    logic [1:0]  width, width_next;
    logic [31:0] addr, addr_next, wdata, wdata_next;
    logic [31:0] irdata, irdata_next, drdata, drdata_next;
    logic        idone, idone_next, ierr, ierr_next;
    logic        ddone, ddone_next, derr, derr_next;
    logic        pick_d, ack_ok, timed_out;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state  <= IDLE;
            count  <= '0;
            grant_d <= 1'b0;
            last_d <= 1'b0;
            cyc    <= 1'b0;
            stb    <= 1'b0;
            rw     <= 1'b0;
            width  <= '0;
            addr   <= '0;
            wdata  <= '0;
            irdata <= '0;
            drdata <= '0;
            idone  <= 1'b0;
            ierr   <= 1'b0;
            ddone  <= 1'b0;
            derr   <= 1'b0;
        end else begin
            state  <= state_next;
            count  <= count_next;
            grant_d <= grant_d_next;
            last_d <= last_d_next;
            cyc    <= cyc_next;
            stb    <= stb_next;
            rw     <= rw_next;
            width  <= width_next;
            addr   <= addr_next;
            wdata  <= wdata_next;
            irdata <= irdata_next;
            drdata <= drdata_next;
            idone  <= idone_next;
            ierr   <= ierr_next;
            ddone  <= ddone_next;
            derr   <= derr_next;
        end
    end

    always_comb begin
        state_next   = state;
        count_next   = count;
        grant_d_next = grant_d;
        last_d_next  = last_d;
        cyc_next     = cyc;
        stb_next     = stb;
        rw_next      = rw;
        width_next   = width;
        addr_next    = addr;
        wdata_next   = wdata;
        irdata_next  = irdata;
        drdata_next  = drdata;
        idone_next   = 1'b0;
        ierr_next    = 1'b0;
        ddone_next   = 1'b0;
        derr_next    = 1'b0;
        ack_ok       = 1'b0;
        timed_out    = 1'b0;
        // On a tie the master that did not win last time takes the bus
        pick_d       = bus.DRequest && (!bus.IRequest || !last_d);

        unique case (state)
            IDLE: begin
                if (bus.IRequest || bus.DRequest) begin
                    grant_d_next = pick_d;
                    last_d_next  = pick_d;
                    width_next   = pick_d ? bus.DWidth     : 2'b10;
                    rw_next      = pick_d ? bus.DWrite     : 1'b0;
                    addr_next    = pick_d ? bus.DAddress   : bus.IAddress;
                    wdata_next   = pick_d ? bus.DWriteData : 32'h0;
                    cyc_next     = 1'b1;
                    stb_next     = 1'b1;
                    count_next   = '0;
                    state_next   = STROBE;
                end
            end
            STROBE: begin
                if (!bus.MemoryBusStall && bus.MemoryBusAcknowledge) begin
                    ack_ok = 1'b1;
                end else if (count == Limit) begin
                    timed_out = 1'b1;
                end else begin
                    count_next = count + 16'd1;
                    if (!bus.MemoryBusStall) begin
                        stb_next   = 1'b0;
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (bus.MemoryBusAcknowledge) begin
                    ack_ok = 1'b1;
                end else if (count == Limit) begin
                    timed_out = 1'b1;
                end else begin
                    count_next = count + 16'd1;
                end
            end
            RESPOND: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        if (ack_ok || timed_out) begin
            state_next = RESPOND;
            cyc_next   = 1'b0;
            stb_next   = 1'b0;
            idone_next = ack_ok && !grant_d;
            ddone_next = ack_ok && grant_d;
            ierr_next  = timed_out && !grant_d;
            derr_next  = timed_out && grant_d;
            if (ack_ok && !rw) begin
                if (grant_d) drdata_next = bus.MemoryDataOut;
                else         irdata_next = bus.MemoryDataOut;
            end
        end
    end

    assign bus.MemoryBusCycle     = cyc;
    assign bus.MemoryBusStrobe    = stb;
    assign bus.MemoryBusReadWrite = rw;
    assign bus.MemoryDataWidth    = width;
    assign bus.MemoryAddress      = addr;
    assign bus.MemoryDataIn       = wdata;
    assign bus.IReadData          = irdata;
    assign bus.DReadData          = drdata;
    assign bus.IDone              = idone;
    assign bus.IError             = ierr;
    assign bus.DDone              = ddone;
    assign bus.DError             = derr;
endmodule

// File: tb/tb_memory_arbiter.sv
// tb/tb_memory_arbiter.sv - directed self-checking bench for memory_arbiter
module tb_memory_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    memory_arbiter_if bus ();

    memory_arbiter #(.TimeoutCycles(8)) dut (
        .Clock (clk),
        .Reset (rst),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.IRequest = 0; bus.IAddress = 0;
        bus.DRequest = 0; bus.DWrite = 0; bus.DWidth = 0; bus.DAddress = 0; bus.DWriteData = 0;
        bus.MemoryDataOut = 0; bus.MemoryBusAcknowledge = 0; bus.MemoryBusStall = 0;

        tick(); tick();
        check("rst_cyc",   32'(bus.MemoryBusCycle),  0);
        check("rst_stb",   32'(bus.MemoryBusStrobe), 0);
        check("rst_addr",  bus.MemoryAddress,        0);
        check("rst_ird",   bus.IReadData,            0);
        check("rst_drd",   bus.DReadData,            0);
        check("rst_done",  32'({bus.IDone, bus.DDone, bus.IError, bus.DError}), 0);
        rst = 0;

        // Instruction read, ack one cycle after strobe acceptance
        bus.IRequest = 1; bus.IAddress = 32'h100; bus.MemoryDataOut = 32'hDEADBEEF;
        tick();
        check("i_stb",   32'(bus.MemoryBusStrobe),    1);
        check("i_cyc",   32'(bus.MemoryBusCycle),     1);
        check("i_rw",    32'(bus.MemoryBusReadWrite), 0);
        check("i_width", 32'(bus.MemoryDataWidth),    2);
        check("i_addr",  bus.MemoryAddress,           32'h100);
        check("i_win",   bus.MemoryDataIn,            0);
        tick();
        check("i_wait_stb", 32'(bus.MemoryBusStrobe), 0);
        check("i_wait_cyc", 32'(bus.MemoryBusCycle),  1);
        check("i_no_done",  32'(bus.IDone),           0);
        bus.MemoryBusAcknowledge = 1;
        tick();
        check("i_done",  32'(bus.IDone),  1);
        check("i_ddone", 32'(bus.DDone),  0);
        check("i_rdata", bus.IReadData,   32'hDEADBEEF);
        check("i_cyc0",  32'(bus.MemoryBusCycle), 0);
        bus.MemoryBusAcknowledge = 0; bus.IRequest = 0;
        tick();
        check("i_done_pulse", 32'(bus.IDone), 0);

        // Acknowledge while idle is ignored
        bus.MemoryBusAcknowledge = 1;
        tick();
        check("idle_ack", 32'({bus.IDone, bus.DDone, bus.MemoryBusCycle}), 0);
        bus.MemoryBusAcknowledge = 0;

        // Data write with three stall cycles; fields must not follow master changes
        bus.DRequest = 1; bus.DWrite = 1; bus.DAddress = 32'h200;
        bus.DWriteData = 32'h12345678; bus.DWidth = 2'b01; bus.MemoryBusStall = 1;
        tick();
        bus.DAddress = 32'h999; bus.DWriteData = 32'hFFFFFFFF; bus.DWidth = 2'b10;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("w_stb%0d", i),   32'(bus.MemoryBusStrobe),    1);
            check($sformatf("w_addr%0d", i),  bus.MemoryAddress,           32'h200);
            check($sformatf("w_data%0d", i),  bus.MemoryDataIn,            32'h12345678);
            check($sformatf("w_width%0d", i), 32'(bus.MemoryDataWidth),    1);
            check($sformatf("w_rw%0d", i),    32'(bus.MemoryBusReadWrite), 1);
            if (i == 3) bus.MemoryBusStall = 0;
            tick();
        end
        check("w_wait_stb", 32'(bus.MemoryBusStrobe), 0);
        bus.MemoryBusAcknowledge = 1; bus.MemoryDataOut = 32'hCAFEF00D;
        tick();
        check("w_done",  32'(bus.DDone), 1);
        check("w_drd",   bus.DReadData,  0);
        bus.MemoryBusAcknowledge = 0; bus.DRequest = 0; bus.DWrite = 0;
        tick();

        // After reset both held: grant order D, I, D with same-cycle ack
        rst = 1; tick(); rst = 0;
        bus.IRequest = 1; bus.IAddress = 32'h1000;
        bus.DRequest = 1; bus.DAddress = 32'h2000; bus.DWidth = 2'b10;
        bus.MemoryBusAcknowledge = 1; bus.MemoryDataOut = 32'h55AA33CC;
        for (int t = 0; t < 3; t++) begin
            tick();
            check($sformatf("rr_cyc%0d", t),  32'(bus.MemoryBusCycle), 1);
            check($sformatf("rr_addr%0d", t), bus.MemoryAddress, (t == 1) ? 32'h1000 : 32'h2000);
            tick();
            check($sformatf("rr_done%0d", t), 32'({bus.IDone, bus.DDone}), (t == 1) ? 32'h2 : 32'h1);
            check($sformatf("rr_cyc0_%0d", t), 32'(bus.MemoryBusCycle), 0);
            tick();
            check($sformatf("rr_idle%0d", t), 32'(bus.MemoryBusCycle), 0);
        end
        check("rr_ird", bus.IReadData, 32'h55AA33CC);
        bus.IRequest = 0; bus.DRequest = 0; bus.MemoryBusAcknowledge = 0;
        tick();

        // Timeout with no acknowledge: error eight cycles after strobe entry
        bus.IRequest = 1; bus.IAddress = 32'h3000; bus.MemoryDataOut = 32'h0;
        tick();
        for (int k = 1; k < 8; k++) begin
            tick();
            check($sformatf("to_run%0d", k), 32'({bus.MemoryBusCycle, bus.IError}), 32'h2);
        end
        tick();
        check("to_err",  32'(bus.IError), 1);
        check("to_done", 32'(bus.IDone),  0);
        check("to_cyc",  32'(bus.MemoryBusCycle), 0);
        check("to_ird",  bus.IReadData, 32'h55AA33CC);
        bus.IRequest = 0;
        tick();
        check("to_pulse", 32'(bus.IError), 0);

        // Reset in WAIT abandons the transfer
        bus.DRequest = 1; bus.DAddress = 32'h300;
        tick();
        tick();
        check("rw_wait", 32'({bus.MemoryBusCycle, bus.MemoryBusStrobe}), 32'h2);
        rst = 1;
        tick();
        rst = 0; bus.DRequest = 0; bus.MemoryBusAcknowledge = 1; bus.MemoryDataOut = 32'h77777777;
        check("rw_cyc",  32'({bus.MemoryBusCycle, bus.MemoryBusStrobe}), 0);
        check("rw_addr", bus.MemoryAddress, 0);
        check("rw_ird",  bus.IReadData, 0);
        tick();
        check("rw_nodone", 32'({bus.DDone, bus.DError, bus.IDone, bus.IError}), 0);
        check("rw_drd",    bus.DReadData, 0);
        bus.MemoryBusAcknowledge = 0;
        bus.IRequest = 1; bus.IAddress = 32'h400; bus.MemoryDataOut = 32'h0BADC0DE;
        tick();
        check("rn_addr", bus.MemoryAddress, 32'h400);
        tick();
        bus.MemoryBusAcknowledge = 1;
        tick();
        check("rn_done",  32'(bus.IDone), 1);
        check("rn_rdata", bus.IReadData,  32'h0BADC0DE);
        bus.MemoryBusAcknowledge = 0; bus.IRequest = 0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameter: TimeoutCycles, 255, cycles allowed from first strobe to acknowledge before the transfer is aborted with an error (range 2..65535).
REQ-002 Clock  in  1  sole clock; all state updates on its rising edge.
REQ-003 Reset  in  1  synchronous, active-high reset.
REQ-004 IRequest  in  1  instruction-cache read request; level, held until IDone or IError.
REQ-005 IAddress  in  32  instruction read address; stable while IRequest is high.
REQ-006 IReadData  out  32  instruction read data; valid in the IDone cycle and held until the next captured read.
REQ-007 IDone / IError  out  1 each  one-cycle completion / timeout pulses to the instruction cache.
REQ-008 DRequest  in  1  data-cache request; level, held until DDone or DError.
REQ-009 DWrite  in  1  1 = write, 0 = read.
REQ-010 DWidth  in  2  00 byte, 01 half, 10 word; 11 is forwarded unchanged.
REQ-011 DAddress / DWriteData  in  32 each  data address and write data; stable while DRequest is high.
REQ-012 DReadData  out  32  data read data; same validity rule as IReadData.
REQ-013 DDone / DError  out  1 each  one-cycle completion / timeout pulses to the data cache.
REQ-014 MemoryDataWidth  out  2; MemoryAddress  out  32; MemoryDataIn  out  32 (write data to memory).
REQ-015 MemoryDataOut  in  32  read data from memory.
REQ-016 MemoryBusCycle, MemoryBusStrobe, MemoryBusReadWrite (1 = write)  out  1 each.
REQ-017 MemoryBusAcknowledge, MemoryBusStall  in  1 each.

Function
REQ-018 All memory-side and master-side outputs are registered.
REQ-019 FSM states: IDLE, STROBE, WAIT, RESPOND; one transfer in flight at most.
REQ-020 IDLE: requests sampled; if none, remain. If exactly one, grant it. If both, grant the master not granted last. Latch address, width, write flag and write data of the winner, then go to STROBE.
REQ-021 Instruction grant drives width 10, ReadWrite 0 and MemoryDataIn 0. Data grant forwards DWidth, DWrite and DWriteData.
REQ-022 STROBE: Cycle = 1, Strobe = 1. Edge with Stall = 0 accepts the strobe.
  - Accepted with Acknowledge = 0: go to WAIT with Strobe = 0.
  - Accepted with Acknowledge = 1 in the same cycle: go to RESPOND.
  - Stall = 1: remain in STROBE with Strobe held.
REQ-023 WAIT: Cycle = 1, Strobe = 0. Acknowledge = 1 captures MemoryDataOut into the winner's read-data register and moves to RESPOND.
REQ-024 RESPOND: Cycle = 0, Strobe = 0. Winner's Done pulses high for exactly this cycle, then return to IDLE. Read data is captured only for reads; writes leave the read-data register unchanged.
REQ-025 Timeout counter:
  - cleared on entry to STROBE;
  - increments each cycle spent in STROBE or WAIT;
  - on reaching TimeoutCycles without an acknowledge: go to RESPOND, pulse the winner's Error instead of Done, read-data register unchanged.
REQ-026 Acknowledge in IDLE or RESPOND is ignored. Stall outside STROBE is ignored.
REQ-027 A request still high in the IDLE cycle after RESPOND is treated as a new request.
REQ-028 Latency: with Stall = 0 and Acknowledge one cycle after strobe acceptance, Done asserts 3 cycles after the request is sampled in IDLE. Back-to-back transfers are 4 cycles apart.
REQ-029 Master address, data or width changes after grant have no effect on the in-flight transfer.

Reset
REQ-030 Reset = 1 at an edge forces:
  - state IDLE and timeout counter 0;
  - all outputs 0, including both read-data registers;
  - last-granted = instruction, so the first tie goes to data.
REQ-031 Reset mid-transfer abandons the transfer: no Done or Error is issued, and Cycle and Strobe are 0 on the next cycle.

Verification
REQ-032 IRequest with IAddress 0x100, no stall, Acknowledge one cycle after strobe, MemoryDataOut 0xDEADBEEF -> Strobe in 1 cycle, ReadWrite 0, width 10, IDone 3 cycles after the request is sampled, IReadData 0xDEADBEEF.
REQ-033 DRequest write with address 0x200, data 0x12345678, width 01, Stall high 3 cycles -> Strobe held 4 cycles with stable fields, ReadWrite 1, DDone pulses, DReadData unchanged.
REQ-034 IRequest and DRequest both held for 3 transfers after reset -> grant order D, I, D, with no overlapping Cycle.
REQ-035 TimeoutCycles = 8 and Acknowledge never asserted -> Error pulse exactly 8 cycles after STROBE entry, Cycle drops, no Done.
REQ-036 Reset asserted in WAIT, then Acknowledge arrives -> no Done, all outputs 0, and the next request is served normally.
